decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/mips_defs.sv | 35 +++
 rtl/regfile.sv | 45 ++++
 rtl/decode_stage.sv | 107 ++++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared opcode constants, control-bundle widths and the main control decoder.
// Latency: pure definitions and a combinational function, no state.
// Backpressure: none here; the decode stage owns stall/bubble insertion.
package mips_defs;

  localparam int WB_W = 2;  // {RegWrite, MemtoReg}
  localparam int M_W  = 3;  // {Branch, MemRead, MemWrite}
  localparam int EX_W = 4;  // {RegDst, ALUOp[1:0], ALUSrc}

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  // Unknown opcodes decode to an all-zero bundle, i.e. a harmless bubble.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.wb = 2'b10; c.m = 3'b000; c.ex = 4'b1100; end
      OP_LW:    begin c.wb = 2'b11; c.m = 3'b010; c.ex = 4'b0001; end
      OP_SW:    begin c.wb = 2'b00; c.m = 3'b001; c.ex = 4'b0001; end
      OP_BEQ:   begin c.wb = 2'b00; c.m = 3'b100; c.ex = 4'b0010; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file, two write-through read ports, register 0 hardwired to zero.
// Latency: reads combinational, writes land on the rising edge.
// Backpressure: none; a write is accepted every cycle it is enabled.
module regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [REG_CNT];
  logic              wr_en;

  // Writes to r0 are dropped so it can never hold a non-zero value.
  assign wr_en = we && (waddr != '0);

  // Storage: reset clears every word and wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: r0 reads zero, a same-cycle write to the address is bypassed.
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (wr_en && (waddr == raddr1)) rdata1 = wdata;
    if (wr_en && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Pipeline ID stage: register read, control decode, sign-extend, ID/EX latch.
// Latency: one cycle from IF_ID_instr/IF_ID_NPC to the ID/EX outputs.
// Backpressure: stall (load-use) and flush turn the latched controls into a bubble.
module decode_stage
  import mips_defs::*;
#(
  parameter int DATA_W  = 32,  // must be >= 16 for the immediate extension
  parameter int REG_CNT = 32,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] MEM_WB_Writereg,
  input  logic [DATA_W-1:0] MEM_WB_Writedata,
  input  logic [31:0]       IF_ID_instr,
  input  logic [DATA_W-1:0] IF_ID_NPC,
  input  logic              flush,
  output logic [WB_W-1:0]   WB,
  output logic [M_W-1:0]    M,
  output logic [EX_W-1:0]   EX,
  output logic [DATA_W-1:0] NPC,
  output logic [DATA_W-1:0] rdata1out,
  output logic [DATA_W-1:0] rdata2out,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] instrout_2521,
  output logic [ADDR_W-1:0] instrout_2016,
  output logic [ADDR_W-1:0] instrout_1511,
  output logic              stall
);

  localparam int EXT_W = DATA_W - 16;

  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_rd;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  ctrl_t             id_ctrl;
  logic              bubble;

  // Register fields keep only the low bits a smaller register file can address.
  assign id_rs   = IF_ID_instr[21 +: ADDR_W];
  assign id_rt   = IF_ID_instr[16 +: ADDR_W];
  assign id_rd   = IF_ID_instr[11 +: ADDR_W];
  assign id_imm  = {{EXT_W{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
  assign id_ctrl = decode_ctrl(IF_ID_instr[31:26]);

  // A load in EX whose destination feeds this instruction cannot be forwarded
  // in time; hold IF/PC and issue a bubble. r0 as destination never conflicts.
  assign stall = M[1] && (instrout_2016 != '0) &&
                 ((instrout_2016 == id_rs) || (instrout_2016 == id_rt));

  // Stall and flush both just zero the controls, so together they still
  // yield exactly one bubble.
  assign bubble = stall || flush;

  regfile #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (RegWrite),
    .waddr (MEM_WB_Writereg),
    .wdata (MEM_WB_Writedata),
    .raddr1(id_rs),
    .raddr2(id_rt),
    .rdata1(id_rdata1),
    .rdata2(id_rdata2)
  );

  // ID/EX latch: data and fields always advance, controls squash on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB            <= '0;
      M             <= '0;
      EX            <= '0;
      NPC           <= '0;
      rdata1out     <= '0;
      rdata2out     <= '0;
      IR            <= '0;
      instrout_2521 <= '0;
      instrout_2016 <= '0;
      instrout_1511 <= '0;
    end else begin
      if (bubble) begin
        WB <= '0;
        M  <= '0;
        EX <= '0;
      end else begin
        WB <= id_ctrl.wb;
        M  <= id_ctrl.m;
        EX <= id_ctrl.ex;
      end
      NPC           <= IF_ID_NPC;
      rdata1out     <= id_rdata1;
      rdata2out     <= id_rdata2;
      IR            <= id_imm;
      instrout_2521 <= id_rs;
      instrout_2016 <= id_rt;
      instrout_1511 <= id_rd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a
// table-driven pipeline model; a second instance covers a 16-entry register file.
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults: 32 x 32)
  logic        rst, RegWrite, flush;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data, instr, npc_in;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [3:0]  EX;
  logic [31:0] NPC, rdata1out, rdata2out, IR;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic        stall;

  decode_stage dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MEM_WB_Writereg(wr_reg),
    .MEM_WB_Writedata(wr_data), .IF_ID_instr(instr), .IF_ID_NPC(npc_in),
    .flush(flush), .WB(WB), .M(M), .EX(EX), .NPC(NPC), .rdata1out(rdata1out),
    .rdata2out(rdata2out), .IR(IR), .instrout_2521(f_rs), .instrout_2016(f_rt),
    .instrout_1511(f_rd), .stall(stall)
  );

  // Small instance (16 registers, 4-bit addresses)
  logic        s_rst, s_we, s_flush;
  logic [3:0]  s_wa;
  logic [31:0] s_wd, s_instr, s_npc;
  logic [1:0]  s_WB;
  logic [2:0]  s_M;
  logic [3:0]  s_EX;
  logic [31:0] s_NPC, s_r1, s_r2, s_IR;
  logic [3:0]  s_rs, s_rt, s_rd;
  logic        s_stall;

  decode_stage #(.DATA_W(32), .REG_CNT(16)) dut16 (
    .clk(clk), .rst(s_rst), .RegWrite(s_we), .MEM_WB_Writereg(s_wa),
    .MEM_WB_Writedata(s_wd), .IF_ID_instr(s_instr), .IF_ID_NPC(s_npc),
    .flush(s_flush), .WB(s_WB), .M(s_M), .EX(s_EX), .NPC(s_NPC), .rdata1out(s_r1),
    .rdata2out(s_r2), .IR(s_IR), .instrout_2521(s_rs), .instrout_2016(s_rt),
    .instrout_1511(s_rd), .stall(s_stall)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; RegWrite = 1'b0; flush = 1'b0;
    wr_reg = '0; wr_data = '0; instr = '0; npc_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; RegWrite = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEADBEEF;
    instr = 32'h8CA5FFFF; npc_in = 32'h1234; flush = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if ({WB, M, EX} !== 9'd0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", {WB, M, EX}); end
    checks++;
    if ({NPC, rdata1out, rdata2out, IR} !== 128'd0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {NPC, rdata1out, rdata2out, IR});
    end
    checks++;
    if ({f_rs, f_rt, f_rd, stall} !== 16'd0) begin
      errors++; $display("FAIL reset_fields got=%h exp=0", {f_rs, f_rt, f_rd, stall});
    end
    instr = 32'd5 << 21;
    tick();
    checks++;
    if (rdata1out !== 32'd0) begin errors++; $display("FAIL reset_r5 got=%h exp=0", rdata1out); end
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; wr_reg = 5'd1; wr_data = 32'h10654321; instr = '0;
    tick();
    wr_reg = 5'd2; wr_data = 32'h00100022;
    tick();
    RegWrite = 1'b0; instr = (32'd1 << 21) | (32'd2 << 16); npc_in = 32'h40;
    tick();
    checks++;
    if (rdata1out !== 32'h10654321) begin errors++; $display("FAIL wr_rd_r1 got=%h exp=10654321", rdata1out); end
    checks++;
    if (rdata2out !== 32'h00100022) begin errors++; $display("FAIL wr_rd_r2 got=%h exp=00100022", rdata2out); end
    checks++;
    if (NPC !== 32'h40) begin errors++; $display("FAIL npc got=%h exp=40", NPC); end
  endtask

  task automatic test_write_through();
    RegWrite = 1'b1; wr_reg = 5'd3; wr_data = 32'h8C123456; instr = (32'd3 << 21);
    tick();
    checks++;
    if (rdata1out !== 32'h8C123456) begin errors++; $display("FAIL wt_r3 got=%h exp=8c123456", rdata1out); end
    checks++;
    if (rdata2out !== 32'd0) begin errors++; $display("FAIL wt_r0 got=%h exp=0", rdata2out); end
    // A write aimed at r0 must neither bypass nor stick.
    wr_reg = 5'd0; wr_data = 32'hFFFFFFFF; instr = (32'd3 << 16);
    tick();
    RegWrite = 1'b0; instr = '0;
    checks++;
    if (rdata1out !== 32'd0 || rdata2out !== 32'h8C123456) begin
      errors++; $display("FAIL r0_write got=%h/%h exp=0/8c123456", rdata1out, rdata2out);
    end
    tick();
    checks++;
    if (rdata1out !== 32'd0) begin errors++; $display("FAIL r0_sticky got=%h exp=0", rdata1out); end
  endtask

  task automatic test_decode_extend();
    instr = 32'h8C22FFFC; npc_in = 32'h44;
    tick();
    checks++;
    if ({WB, M, EX} !== {2'b11, 3'b010, 4'b0001}) begin
      errors++; $display("FAIL lw_ctrl got=%b exp=110100001", {WB, M, EX});
    end
    checks++;
    if (IR !== 32'hFFFFFFFC) begin errors++; $display("FAIL sext got=%h exp=fffffffc", IR); end
    checks++;
    if (f_rt !== 5'd2 || f_rs !== 5'd1 || rdata1out !== 32'h10654321) begin
      errors++; $display("FAIL lw_fields got=%h/%h/%h exp=2/1/10654321", f_rt, f_rs, rdata1out);
    end
  endtask

  task automatic test_load_use();
    instr = (32'd2 << 21) | (32'd5 << 16) | (32'd7 << 11);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if ({WB, M, EX} !== 9'd0 || f_rs !== 5'd2) begin
      errors++; $display("FAIL lu_bubble got=%b rs=%h exp=0 rs=2", {WB, M, EX}, f_rs);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall); end
    instr = 32'h8C200004;
    tick();
    checks++;
    if (M !== 3'b010 || f_rt !== 5'd0) begin errors++; $display("FAIL lw_r0 got=%b/%h exp=010/0", M, f_rt); end
    instr = (32'd3 << 16);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_flush();
    instr = 32'h8C220000;
    tick();
    instr = (32'd1 << 21) | (32'd2 << 16) | (32'd4 << 11); flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL fl_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if ({WB, M, EX} !== 9'd0 || f_rd !== 5'd4 || rdata1out !== 32'h10654321) begin
      errors++; $display("FAIL fl_both got=%b rd=%h r1=%h exp=0 rd=4 r1=10654321", {WB, M, EX}, f_rd, rdata1out);
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({WB, M, EX} !== 9'd0) begin errors++; $display("FAIL fl_rtype got=%b exp=0", {WB, M, EX}); end
    tick();
    checks++;
    if ({WB, M, EX} !== {2'b10, 3'b000, 4'b1100}) begin
      errors++; $display("FAIL rtype_ctrl got=%b exp=100001100", {WB, M, EX});
    end
  endtask

  // Reference: architectural register array plus the ID/EX latch contents.
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] mref [32];
    logic [8:0]  e_ctrl;
    logic [31:0] e_npc, e_r1, e_r2, e_ir;
    logic [4:0]  e_rs, e_rt, e_rd, rs, rt;
    logic [5:0]  op;
    logic        e_stall;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) mref[i] = '0;
    e_ctrl = '0; e_npc = '0; e_r1 = '0; e_r2 = '0; e_ir = '0;
    e_rs = '0; e_rt = '0; e_rd = '0;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      RegWrite = 1'($urandom_range(0, 1));
      wr_reg   = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      flush    = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = 6'($urandom_range(0, 63));
      endcase
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      instr  = {op, rs, rt, 5'($urandom_range(0, 31)), 11'($urandom)};
      npc_in = $urandom;
      #1;
      e_stall = e_ctrl[5] && (e_rt != 0) && (e_rt == rs || e_rt == rt);
      checks++;
      if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
      tick();
      if (rst) begin
        for (int i = 0; i < 32; i++) mref[i] = '0;
        e_ctrl = '0; e_npc = '0; e_r1 = '0; e_r2 = '0; e_ir = '0;
        e_rs = '0; e_rt = '0; e_rd = '0;
      end else begin
        e_r1 = (rs == 0) ? 32'd0 : (RegWrite && wr_reg == rs) ? wr_data : mref[rs];
        e_r2 = (rt == 0) ? 32'd0 : (RegWrite && wr_reg == rt) ? wr_data : mref[rt];
        e_ctrl = (e_stall || flush) ? 9'd0 : ctrl_of(op);
        e_npc = npc_in;
        e_ir  = 32'($signed(instr[15:0]));
        e_rs = rs; e_rt = rt; e_rd = instr[15:11];
        if (RegWrite && wr_reg != 0) mref[wr_reg] = wr_data;
      end
      checks++;
      if ({WB, M, EX} !== e_ctrl) begin errors++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, {WB, M, EX}, e_ctrl); end
      checks++;
      if (rdata1out !== e_r1 || rdata2out !== e_r2) begin
        errors++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, rdata1out, rdata2out, e_r1, e_r2);
      end
      checks++;
      if (NPC !== e_npc || IR !== e_ir || {f_rs, f_rt, f_rd} !== {e_rs, e_rt, e_rd}) begin
        errors++; $display("FAIL rnd_misc c=%0d got=%h/%h/%h exp=%h/%h/%h", c, NPC, IR, {f_rs, f_rt, f_rd}, e_npc, e_ir, {e_rs, e_rt, e_rd});
      end
    end
    idle_inputs();
  endtask

  task automatic test_small_rf();
    s_rst = 1'b0; s_we = 1'b1; s_wa = 4'd1; s_wd = 32'h10654321;
    tick();
    s_wa = 4'd2; s_wd = 32'h00100022;
    tick();
    s_we = 1'b0; s_instr = (32'd1 << 21) | (32'd2 << 16);
    tick();
    checks++;
    if (s_r1 !== 32'h10654321 || s_r2 !== 32'h00100022) begin
      errors++; $display("FAIL rf16_read got=%h/%h exp=10654321/00100022", s_r1, s_r2);
    end
    checks++;
    if (s_rs !== 4'd1 || s_rt !== 4'd2 || s_WB !== 2'b10) begin
      errors++; $display("FAIL rf16_fields got=%h/%h/%b exp=1/2/10", s_rs, s_rt, s_WB);
    end
  endtask

  initial begin
    idle_inputs();
    s_rst = 1'b1; s_we = 1'b0; s_flush = 1'b0; s_wa = '0; s_wd = '0;
    s_instr = '0; s_npc = '0;
    tick();
    test_reset();
    test_write_read();
    test_write_through();
    test_decode_extend();
    test_load_use();
    test_flush();
    test_random();
    test_small_rf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
